// File: rtl/smart_home_pkg.sv
// Shared types and constants for the smart-home climate path.
// Holds the sensor FSM encoding, fault code and temperature saturation helper.
package smart_home_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, UPDATE} sensor_state_t;

  localparam logic [7:0] SENSOR_FAULT_CODE  = 8'hFF;
  localparam logic [4:0] TEMP_MAX           = 5'd31;
  localparam int         DEFAULT_RESET_TEMP = 20;

  function automatic logic [4:0] sat5(input logic [7:0] v);
    return (v > {3'b000, TEMP_MAX}) ? TEMP_MAX : v[4:0];
  endfunction

endpackage

// File: rtl/moving_avg_filter.sv
// Moving average over the last 2^AVG_LOG2 samples using a running sum.
// The first sample after reset fills every tap, so the first output equals it.
module moving_avg_filter #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_avg
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 8 + AVG_LOG2;

  logic [DEPTH-1:0][7:0] buf_q;
  logic [SW-1:0]         sum_q, sum_nxt;
  logic                  primed_q;

  // buf_q[DEPTH-1] is the oldest tap, leaving the window on this push
  assign sum_nxt = sum_q + SW'(in_data) - SW'(buf_q[DEPTH-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q     <= '0;
      sum_q     <= '0;
      primed_q  <= 1'b0;
      out_valid <= 1'b0;
      out_avg   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (!primed_q) begin
          buf_q    <= {DEPTH{in_data}};
          sum_q    <= SW'(in_data) << AVG_LOG2;
          primed_q <= 1'b1;
          out_avg  <= in_data;
        end else begin
          for (int i = DEPTH-1; i > 0; i--) buf_q[i] <= buf_q[i-1];
          buf_q[0] <= in_data;
          sum_q    <= sum_nxt;
          out_avg  <= 8'(sum_nxt >> AVG_LOG2);
        end
      end
    end
  end

endmodule

// File: rtl/temp_sensor_if.sv
// SPI-style temperature sensor reader: periodic 8-bit frames, moving-average
// smoothing, 5-bit saturation and stuck-bus (8'hFF) fault flag.
module temp_sensor_if
  import smart_home_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int RESET_TEMP    = DEFAULT_RESET_TEMP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_miso,
  output logic       sensor_sclk,
  output logic       sensor_cs_n,
  output logic [4:0] temperature,
  output logic       temp_valid,
  output logic       sensor_fault
);
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = $clog2(CLK_DIV + 1);

  sensor_state_t state_q, state_d;
  logic [PW-1:0] per_q;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    half_q, half_d;
  logic          sclk_q, sclk_d, cs_n_q, cs_n_d, fault_q, fault_d;
  logic [7:0]    sh_q, sh_d;
  logic [4:0]    temp_q;
  logic          tvld_q, push, div_last, filt_vld;
  logic [7:0]    filt_avg;

  assign div_last = (div_q == DW'(CLK_DIV - 1));

  // half_q counts sclk half-periods: even = low, odd = high; half 16 is the
  // trailing low hold before chip select is released
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    sh_d    = sh_q;
    fault_d = fault_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (per_q == '0) begin
        state_d = SETUP;
        cs_n_d  = 1'b0;
        div_d   = '0;
      end
      SETUP: if (div_last) begin
        state_d = SHIFT;
        div_d   = '0;
        half_d  = '0;
      end else div_d = div_q + DW'(1);
      SHIFT: if (div_last) begin
        div_d  = '0;
        half_d = half_q + 5'd1;
        if (half_q == 5'd16) begin
          state_d = UPDATE;
          cs_n_d  = 1'b1;
        end else if (!half_q[0]) begin
          sclk_d = 1'b1;
          sh_d   = {sh_q[6:0], sensor_miso};
        end else sclk_d = 1'b0;
      end else div_d = div_q + DW'(1);
      UPDATE: begin
        state_d = IDLE;
        if (sh_q == SENSOR_FAULT_CODE) fault_d = 1'b1;
        else begin
          fault_d = 1'b0;
          push    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      div_q   <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sh_q    <= '0;
      fault_q <= 1'b0;
      temp_q  <= 5'(RESET_TEMP);
      tvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= (per_q == PW'(SAMPLE_PERIOD - 1)) ? '0 : per_q + PW'(1);
      div_q   <= div_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      sh_q    <= sh_d;
      fault_q <= fault_d;
      tvld_q  <= filt_vld;
      if (filt_vld) temp_q <= sat5(filt_avg);
    end
  end

  moving_avg_filter #(.AVG_LOG2(AVG_LOG2)) u_filt (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_data   (sh_q),
    .out_valid (filt_vld),
    .out_avg   (filt_avg)
  );

  assign sensor_sclk  = sclk_q;
  assign sensor_cs_n  = cs_n_q;
  assign temperature  = temp_q;
  assign temp_valid   = tvld_q;
  assign sensor_fault = fault_q;

endmodule

// File: tb/tb_temp_sensor_if.sv
// Directed bench for temp_sensor_if with a behavioural SPI sensor model.
module tb_temp_sensor_if;
  localparam int CD = 2;
  localparam int SP = 64;
  localparam int FRAME_LAT = 18*CD + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_miso, sensor_sclk, sensor_cs_n, temp_valid, sensor_fault;
  logic [4:0] temperature;

  temp_sensor_if #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .AVG_LOG2(2), .RESET_TEMP(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_miso  (sensor_miso),
    .sensor_sclk  (sensor_sclk),
    .sensor_cs_n  (sensor_cs_n),
    .temperature  (temperature),
    .temp_valid   (temp_valid),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int cs_fall_cnt = 0, cs_fall_cyc = 0, tv_cnt = 0, tv_cyc = 0;
  int rise_cnt = 0, first_rise_cyc = 0, last_rise_cyc = 0;
  bit first_pending = 1'b0;
  int pass_cnt = 0, tot_cnt = 0;

  logic [7:0] sensor_byte = 8'h00, frame_byte = 8'h00;
  logic [2:0] bit_idx = 3'd7;

  always @(negedge clk) cyc++;

  // sensor model: latches the byte at frame start, shifts MSB first on each sclk rise
  always @(negedge sensor_cs_n) begin
    frame_byte    = sensor_byte;
    bit_idx       = 3'd7;
    cs_fall_cnt++;
    cs_fall_cyc   = cyc;
    first_pending = 1'b1;
  end
  always @(posedge sensor_sclk) begin
    rise_cnt++;
    last_rise_cyc = cyc;
    if (first_pending) begin
      first_rise_cyc = cyc;
      first_pending  = 1'b0;
    end
    if (bit_idx != 3'd0) bit_idx = bit_idx - 3'd1;
  end
  assign sensor_miso = frame_byte[bit_idx];

  always @(posedge temp_valid) begin
    tv_cnt++;
    tv_cyc = cyc;
  end

  // run one frame with the given sensor byte; bounded waits on frame start and temp_valid
  task automatic do_frame(input logic [7:0] b, output logic fell, output logic got, output int lat);
    int n0, v0;
    sensor_byte = b;
    fell = 1'b0; got = 1'b0; lat = -1;
    n0 = cs_fall_cnt;
    for (int i = 0; i < SP + 10 && cs_fall_cnt == n0; i++) @(negedge clk);
    if (cs_fall_cnt == n0) return;
    fell = 1'b1;
    v0 = tv_cnt;
    for (int i = 0; i < 60 && tv_cnt == v0; i++) @(negedge clk);
    if (tv_cnt != v0) begin
      got = 1'b1;
      lat = tv_cyc - cs_fall_cyc;
    end
  endtask

  task automatic release_rst(output int rel);
    @(posedge clk);
    #1 rst = 1'b1;
    rel = cyc;
  endtask

  task automatic test_reset();
    logic fell, got; int lat, rel, r0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tot_cnt++;
    if ({sensor_cs_n, sensor_sclk, temperature, temp_valid, sensor_fault} !== {1'b1, 1'b0, 5'd20, 1'b0, 1'b0})
      $display("FAIL reset_outs: got cs_n=%b sclk=%b temp=%0d vld=%b fault=%b, want 1 0 20 0 0",
               sensor_cs_n, sensor_sclk, temperature, temp_valid, sensor_fault);
    else pass_cnt++;
    tot_cnt++;
    if (cs_fall_cnt !== 0) $display("FAIL reset_no_frame: got %0d frame starts, want 0", cs_fall_cnt);
    else pass_cnt++;
    r0 = rise_cnt;
    release_rst(rel);
    do_frame(8'h16, fell, got, lat);
    tot_cnt++;
    if (cs_fall_cyc !== rel + 1) $display("FAIL first_frame_start: got cycle %0d, want %0d", cs_fall_cyc, rel + 1);
    else pass_cnt++;
    tot_cnt++;
    if (got !== 1'b1 || lat !== FRAME_LAT) $display("FAIL frame_latency: got valid=%b lat=%0d, want 1 %0d", got, lat, FRAME_LAT);
    else pass_cnt++;
    tot_cnt++;
    if (temperature !== 5'd22) $display("FAIL primed_temp: got %0d, want 22", temperature);
    else pass_cnt++;
    tot_cnt++;
    if (rise_cnt - r0 !== 8) $display("FAIL sclk_pulses: got %0d, want 8", rise_cnt - r0);
    else pass_cnt++;
    tot_cnt++;
    if (first_rise_cyc - cs_fall_cyc !== 2*CD || last_rise_cyc - cs_fall_cyc !== 16*CD)
      $display("FAIL sclk_timing: got first=%0d last=%0d, want %0d %0d",
               first_rise_cyc - cs_fall_cyc, last_rise_cyc - cs_fall_cyc, 2*CD, 16*CD);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (temp_valid !== 1'b0 || sensor_fault !== 1'b0)
      $display("FAIL valid_pulse: got vld=%b fault=%b one cycle later, want 0 0", temp_valid, sensor_fault);
    else pass_cnt++;
  endtask

  task automatic test_average();
    logic fell, got; int lat;
    logic [4:0] exp_t [4] = '{5'd24, 5'd26, 5'd28, 5'd30};
    for (int k = 0; k < 4; k++) begin
      do_frame(8'd30, fell, got, lat);
      tot_cnt++;
      if (got !== 1'b1 || temperature !== exp_t[k])
        $display("FAIL avg_%0d: got valid=%b temp=%0d, want 1 %0d", k, got, temperature, exp_t[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fault();
    logic fell, got; int lat;
    do_frame(8'hFF, fell, got, lat);
    tot_cnt++;
    if (fell !== 1'b1 || got !== 1'b0 || sensor_fault !== 1'b1 || temperature !== 5'd30)
      $display("FAIL fault_frame: got start=%b valid=%b fault=%b temp=%0d, want 1 0 1 30",
               fell, got, sensor_fault, temperature);
    else pass_cnt++;
    do_frame(8'h14, fell, got, lat);
    tot_cnt++;
    if (got !== 1'b1 || sensor_fault !== 1'b0 || temperature !== 5'd27)
      $display("FAIL fault_recover: got valid=%b fault=%b temp=%0d, want 1 0 27", got, sensor_fault, temperature);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic fell, got; int lat, rel;
    logic [7:0] in_b  [6] = '{8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128};
    logic [4:0] exp_t [6] = '{5'd31, 5'd31, 5'd31, 5'd25, 5'd0, 5'd31};
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    release_rst(rel);
    for (int k = 0; k < 6; k++) begin
      do_frame(in_b[k], fell, got, lat);
      tot_cnt++;
      if (got !== 1'b1 || temperature !== exp_t[k])
        $display("FAIL sat_%0d: in=%0d got valid=%b temp=%0d, want 1 %0d", k, in_b[k], got, temperature, exp_t[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_cadence();
    logic fell, got; int lat;
    int starts [5];
    logic [7:0] in_b [5] = '{8'd5, 8'hFF, 8'd6, 8'd7, 8'hFF};
    for (int k = 0; k < 5; k++) begin
      do_frame(in_b[k], fell, got, lat);
      starts[k] = fell ? cs_fall_cyc : -1000;
    end
    for (int k = 1; k < 5; k++) begin
      tot_cnt++;
      if (starts[k] - starts[k-1] !== SP)
        $display("FAIL cadence_%0d: got spacing %0d, want %0d", k, starts[k] - starts[k-1], SP);
      else pass_cnt++;
    end
    tot_cnt++;
    if (sensor_fault !== 1'b1) $display("FAIL cadence_fault: got %b, want 1", sensor_fault);
    else pass_cnt++;
  endtask

  task automatic test_midframe_reset();
    logic fell, got; int lat, rel, n0, r0;
    sensor_byte = 8'h33;
    n0 = cs_fall_cnt;
    for (int i = 0; i < SP + 10 && cs_fall_cnt == n0; i++) @(negedge clk);
    r0 = rise_cnt;
    for (int i = 0; i < 40 && rise_cnt < r0 + 4; i++) @(negedge clk);
    tot_cnt++;
    if (rise_cnt - r0 !== 4 || sensor_sclk !== 1'b1)
      $display("FAIL midframe_reach: got rises=%0d sclk=%b, want 4 1", rise_cnt - r0, sensor_sclk);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    tot_cnt++;
    if ({sensor_cs_n, sensor_sclk, temperature, temp_valid, sensor_fault} !== {1'b1, 1'b0, 5'd20, 1'b0, 1'b0})
      $display("FAIL midframe_reset_outs: got cs_n=%b sclk=%b temp=%0d vld=%b fault=%b, want 1 0 20 0 0",
               sensor_cs_n, sensor_sclk, temperature, temp_valid, sensor_fault);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    tot_cnt++;
    if (temp_valid !== 1'b0 || temperature !== 5'd20)
      $display("FAIL midframe_no_update: got vld=%b temp=%0d, want 0 20", temp_valid, temperature);
    else pass_cnt++;
    release_rst(rel);
    do_frame(8'd10, fell, got, lat);
    tot_cnt++;
    if (cs_fall_cyc !== rel + 1) $display("FAIL restart_start: got cycle %0d, want %0d", cs_fall_cyc, rel + 1);
    else pass_cnt++;
    tot_cnt++;
    if (got !== 1'b1 || lat !== FRAME_LAT || temperature !== 5'd10)
      $display("FAIL restart_primed: got valid=%b lat=%0d temp=%0d, want 1 %0d 10", got, lat, temperature, FRAME_LAT);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_average();
    test_fault();
    test_saturate();
    test_cadence();
    test_midframe_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, tot_cnt);
    $fatal(1);
  end

endmodule
